// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - instruction fetch stage with IF/ID pipeline register
module fetch_stage_ctrl #(
  parameter int ADDRESS_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC = '0,
  parameter logic [ADDRESS_LEN-1:0] PC_STEP = ADDRESS_LEN'(4)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic                   valid_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [ADDRESS_LEN-1:0] pc_out_q, pc_out_d;
  logic [ADDRESS_LEN-1:0] ins_q, ins_d;
  logic                   valid_q, valid_d;
  logic [ADDRESS_LEN-1:0] buf_pc_q, buf_pc_d;
  logic [ADDRESS_LEN-1:0] buf_ins_q, buf_ins_d;
  logic [ADDRESS_LEN-1:0] pc_next;

  // Sequential successor of the current PC; wraps naturally modulo 2^ADDRESS_LEN.
  assign pc_next = pc_q + PC_STEP;

  // A request is only presented while fetching, and never while reset is held.
  assign imem_req        = (state_q == S_FETCH) && !rst;
  assign imem_addr       = pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = ins_q;
  assign valid_out       = valid_q;

  // State, PC, hold buffer and IF/ID register, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pc_out_q  <= '0;
      ins_q     <= '0;
      valid_q   <= 1'b0;
      buf_pc_q  <= '0;
      buf_ins_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      ins_q     <= ins_d;
      valid_q   <= valid_d;
      buf_pc_q  <= buf_pc_d;
      buf_ins_q <= buf_ins_d;
    end
  end

  // Next state and next register contents; a taken branch overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    ins_d     = ins_q;
    valid_d   = valid_q;
    buf_pc_d  = buf_pc_q;
    buf_ins_d = buf_ins_q;

    if (branch_taken) begin
      // Flush IF/ID and the buffer; a response arriving this cycle is dropped.
      pc_d      = branch_addr;
      pc_out_d  = '0;
      ins_d     = '0;
      valid_d   = 1'b0;
      buf_pc_d  = '0;
      buf_ins_d = '0;
      // Without a response this cycle one is still in flight and must be drained.
      state_d   = (state_q == S_FETCH && !imem_ready) ? S_DRAIN : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_next;
            if (freeze) begin
              // Decode is stalled: park the word so it is not lost.
              buf_pc_d  = pc_next;
              buf_ins_d = imem_rdata;
              state_d   = S_HOLD;
            end else begin
              pc_out_d = pc_next;
              ins_d    = imem_rdata;
              valid_d  = 1'b1;
            end
          end else if (!freeze) begin
            pc_out_d = '0;
            ins_d    = '0;
            valid_d  = 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            pc_out_d = buf_pc_q;
            ins_d    = buf_ins_q;
            valid_d  = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_DRAIN: begin
          // The stale response belongs to the old path; keep decode fed with bubbles.
          pc_out_d = '0;
          ins_d    = '0;
          valid_d  = 1'b0;
          if (imem_ready) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
Instruction-fetch stage plus IF/ID pipeline register; the producer side of the decode stage's pc_in/instruction inputs.
- Holds the PC and issues word fetches to an instruction memory with variable latency (req/ready handshake).
- Freezes on hazard or multi-cycle freeze from decode, redirects and flushes on a taken branch from execute.
- Presents {pc+4, instruction, valid} to decode.

Parameters:
ADDRESS_LEN, 32, width of PC, addresses and instruction words
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
freeze  input  1  decode cannot accept (Hazard OR cycle_freeze)
branch_taken  input  1  taken branch from execute; redirect and flush
branch_addr  input  ADDRESS_LEN  branch target
imem_req  output  1  fetch request valid
imem_addr  output  ADDRESS_LEN  fetch address (= PC)
imem_ready  input  1  one-cycle pulse: imem_rdata valid for the current request
imem_rdata  input  ADDRESS_LEN  fetched instruction word
pc_out  output  ADDRESS_LEN  PC+PC_STEP of the instruction in IF/ID
instruction_out  output  ADDRESS_LEN  instruction in IF/ID (0 = bubble)
valid_out  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate): PC=RESET_PC, state=FETCH, pc_out=0, instruction_out=0, valid_out=0, hold buffer cleared, imem_req=0 while rst high. A reset mid-request abandons it; memory must tolerate this.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_ready with no branch and no freeze: IF/ID <= {PC+PC_STEP, imem_rdata, 1}; PC += PC_STEP. Stay in FETCH, with a new request next cycle.
  - On imem_ready with freeze: hold buffer <= {PC+PC_STEP, imem_rdata}; PC += PC_STEP; go to HOLD. IF/ID unchanged.
  - No imem_ready, no freeze: IF/ID <= bubble (0, 0, valid 0).
  - No imem_ready, freeze: IF/ID unchanged.
- HOLD:
  - imem_req=0.
  - While freeze is high, IF/ID and buffer are unchanged.
  - When freeze is low: IF/ID <= {buffer, valid 1}; go to FETCH.
- DRAIN:
  - imem_req=0 and imem_addr=PC (the new target). The outstanding response is awaited and discarded.
  - On imem_ready go to FETCH. IF/ID is held as bubble.
- branch_taken (any state, highest priority, overrides freeze):
  - PC <= branch_addr. IF/ID <= bubble. Hold buffer invalidated.
  - From FETCH without imem_ready the same cycle, go to DRAIN. Otherwise go to FETCH.
  - A response arriving in the branch cycle is discarded.
- Latency: an instruction reaches IF/ID on the edge after the imem_ready cycle. Zero-wait memory (ready every cycle) sustains one instruction per cycle.
- PC arithmetic is modulo 2^ADDRESS_LEN, so wrap from 0xFFFFFFFC gives 0. No alignment checking.
- freeze does not affect PC in FETCH before a response arrives; the request stays asserted with a stable address.

Test Plan:
- Reset then zero-wait memory returning addr+0xE000_0000: pc_out/instruction_out sequence is 4/0xE0000000, 8/0xE0000004, 12/0xE0000008, with valid_out=1 from the 2nd edge after reset release.
- Memory with 2 wait cycles: bubbles (valid_out=0, instruction_out=0) appear between instructions, and imem_addr stays stable during the wait.
- freeze high for 3 cycles coinciding with imem_ready at PC=8: IF/ID holds prior instruction, imem_req=0 during HOLD, then instruction@8 appears with pc_out=12 one edge after freeze drops, and no instruction is lost or duplicated.
- branch_taken to 0x100 while a request is pending (ready arrives 2 cycles later): that response is discarded, the next valid_out has pc_out=0x104, and IF/ID shows a bubble in the branch cycle.
- branch_taken and freeze both high in HOLD: branch wins, buffer is dropped, and fetch resumes at branch_addr.
- rst asserted mid-request and released: outputs go to 0 asynchronously, and the first fetch after release is at RESET_PC.
